stim_sequencer: RTL and testbench
=================================

Name: stim_sequencer

Overview:
Synthesizable, parametrised stimulus sequencer for the Segway full-chip bench and FPGA bring-up. It replaces hand-written sequences of send-command / set-inputs / wait-N-cycles with a programmable step table. Each step updates rider lean and the A2D channel values (load cells, steer pot, battery), optionally sends one UART command byte through a UART_tx-style trmt/tx_done handshake, then holds for a programmed delay. It sits between the bench (or a host register port) and the UART_tx, SegwayModel and A2D model stimulus inputs.

Parameters:
DEPTH, 16, number of step-table entries (power of two, >=2)
DLY_W, 24, width of per-step delay count, in clk cycles
NUM_A2D, 4, number of A2D stimulus channels (order: ld_cell_lft, ld_cell_rght, steerPot, batt)
A2D_W, 12, width of each A2D channel value
LEAN_W, 16, width of the signed rider_lean value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_en  in  1  write step-table entry
wr_addr  in  $clog2(DEPTH)  entry index
wr_cmd_vld  in  1  step sends a UART command
wr_cmd  in  8  command byte (e.g. 8'h67 go, 8'h73 stop)
wr_lean  in  LEAN_W  signed rider lean for the step
wr_a2d  in  NUM_A2D*A2D_W  packed A2D values; channel 0 in the LSBs
wr_dly  in  DLY_W  hold cycles after the step's command completes
wr_last  in  1  marks the final step
start  in  1  begin execution at entry 0
abort  in  1  stop execution immediately
loop_en  in  1  on the last step, restart at entry 0 instead of finishing
tx_done  in  1  UART transmit-complete, one-cycle pulse
trmt  out  1  UART transmit strobe
tx_data  out  8  UART byte
rider_lean  out  LEAN_W  signed lean stimulus
a2d_val  out  NUM_A2D*A2D_W  packed A2D stimulus
busy  out  1  sequence executing
done  out  1  one-cycle pulse at normal completion
step_idx  out  $clog2(DEPTH)  entry currently executing

Behaviour:
- Reset (async, rst=1): state IDLE. trmt, tx_data, rider_lean, a2d_val, busy, done and step_idx all 0. Table contents are not reset.
- Writes are accepted only in IDLE or DONE. wr_en while busy is ignored.
- FSM states: IDLE, APPLY, SEND, WAIT_TX, DELAY, DONE. busy=1 in APPLY, SEND, WAIT_TX and DELAY.
- IDLE/DONE + start=1 -> APPLY, with step_idx=0.
- APPLY (1 cycle): registers rider_lean, a2d_val and tx_data from entry[step_idx]. The new values are visible from the next cycle. Goes to SEND if cmd_vld=1, else to DELAY.
- SEND (1 cycle): trmt=1 for exactly one cycle, then WAIT_TX.
- WAIT_TX: holds until tx_done=1, then DELAY. tx_done in any other state is ignored.
- DELAY: the counter loads dly on entry and the FSM stays exactly dly cycles; dly=0 means zero cycles, i.e. the step-end decision is made in the same cycle. A full DLY_W count is legal, with no wrap.
- Step end: if last=1 or step_idx==DEPTH-1:
  - loop_en=1 -> step_idx=0, APPLY.
  - otherwise -> DONE with done=1 for one cycle, then remain in DONE with done=0.
- Step end otherwise: step_idx+1, then APPLY.
- abort=1 in any state -> IDLE next cycle. trmt is forced 0; rider_lean, a2d_val and tx_data hold their last values. abort and start together: abort wins.
- start while busy is ignored. loop_en is sampled only at step end.
- Minimum step time: no command = 1+dly cycles; with command = 2+tx latency+dly cycles.

Decomposition:
- stim_pkg: step_t packed struct {cmd_vld, cmd[7:0], lean, a2d, dly, last}, the state_t enum, and the command constants CMD_GO=8'h67 and CMD_STOP=8'h73.
- Sub-module stim_step_mem: DEPTH x $bits(step_t) register file with a synchronous write and an asynchronous read indexed by step_idx.

Test Plan:
- Reset mid-DELAY: rst pulsed -> all outputs 0 in the same cycle, busy 0, state IDLE.
- Program entry 0 = {go 8'h67, lean 0, a2d 400/400/800/FFF, dly 10, last}, then start -> a2d valid at cycle 2, trmt one cycle at cycle 2 with tx_data=8'h67; tx_done returned at cycle 20 -> done pulse at cycle 31.
- Three steps with leans 16'h0FFF, 16'h0000, 16'hF001, dly 5, no commands -> rider_lean changes every 6 cycles; done after the third step; step_idx goes 0,1,2.
- loop_en=1 with 2 steps -> after step 1, step_idx returns to 0, no done pulse; clearing loop_en gives done at the next wrap.
- abort in WAIT_TX -> IDLE next cycle, trmt stays 0, a2d/lean held; a subsequent start replays from entry 0; start+abort in the same cycle -> stays IDLE.
- DEPTH-1 entry with last=0 and dly=0 on all steps -> each no-command step takes 1 cycle; ends in DONE after entry 15; wr_en during busy leaves the table unchanged.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared types for the stimulus sequencer: step-table entry, FSM states
// and the UART command bytes understood by the Segway controller.
package stim_pkg;

  localparam int PKG_DLY_W   = 24;
  localparam int PKG_NUM_A2D = 4;
  localparam int PKG_A2D_W   = 12;
  localparam int PKG_LEAN_W  = 16;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef struct packed {
    logic                             cmd_vld;
    logic [7:0]                       cmd;
    logic [PKG_LEAN_W-1:0]            lean;
    logic [PKG_NUM_A2D*PKG_A2D_W-1:0] a2d;
    logic [PKG_DLY_W-1:0]             dly;
    logic                             last;
  } step_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SEND,
    S_WAIT_TX,
    S_DELAY,
    S_DONE
  } state_t;

endpackage

// File: rtl/stim_step_mem.sv
// Step table: register file with synchronous write and asynchronous read.
// Contents are deliberately not reset.
module stim_step_mem
  import stim_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  step_t                    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output step_t                    rd_data
);

  step_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stim_sequencer.sv
// Programmable stimulus sequencer: walks a step table, driving lean/A2D
// stimulus, optional UART command bytes and per-step hold delays.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DLY_W   = PKG_DLY_W,
  parameter int NUM_A2D = PKG_NUM_A2D,
  parameter int A2D_W   = PKG_A2D_W,
  parameter int LEAN_W  = PKG_LEAN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic                     wr_cmd_vld,
  input  logic [7:0]               wr_cmd,
  input  logic [LEAN_W-1:0]        wr_lean,
  input  logic [NUM_A2D*A2D_W-1:0] wr_a2d,
  input  logic [DLY_W-1:0]         wr_dly,
  input  logic                     wr_last,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_en,
  input  logic                     tx_done,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  output logic [LEAN_W-1:0]        rider_lean,
  output logic [NUM_A2D*A2D_W-1:0] a2d_val,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW = $clog2(DEPTH);

  state_t           state, state_nxt;
  step_t            wdat, cur;
  logic [AW-1:0]    idx_nxt;
  logic [DLY_W-1:0] cnt, cnt_nxt;
  logic             done_nxt;
  logic             step_end;
  logic             last_step;
  logic             wr_ok;

  assign wr_ok = wr_en && (state == S_IDLE || state == S_DONE);

  assign wdat = '{
    cmd_vld: wr_cmd_vld,
    cmd:     wr_cmd,
    lean:    wr_lean,
    a2d:     wr_a2d,
    dly:     wr_dly,
    last:    wr_last
  };

  stim_step_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wdat),
    .rd_addr (step_idx),
    .rd_data (cur)
  );

  assign last_step = cur.last || (step_idx == AW'(DEPTH - 1));

  // A zero delay resolves the step end in the cycle that would enter DELAY.
  always_comb begin
    state_nxt = state;
    idx_nxt   = step_idx;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    step_end  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_APPLY;
          idx_nxt   = '0;
        end
      end
      S_APPLY: begin
        if (cur.cmd_vld) begin
          state_nxt = S_SEND;
        end else begin
          state_nxt = S_DELAY;
          cnt_nxt   = cur.dly;
          step_end  = (cur.dly == '0);
        end
      end
      S_SEND: state_nxt = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done) begin
          state_nxt = S_DELAY;
          cnt_nxt   = cur.dly;
          step_end  = (cur.dly == '0);
        end
      end
      S_DELAY: begin
        cnt_nxt  = cnt - DLY_W'(1);
        step_end = (cnt == DLY_W'(1));
      end
      default: state_nxt = S_IDLE;
    endcase
    if (step_end) begin
      if (last_step && !loop_en) begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = S_APPLY;
        idx_nxt   = last_step ? '0 : step_idx + AW'(1);
      end
    end
    if (abort) begin
      state_nxt = S_IDLE;
      idx_nxt   = step_idx;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      step_idx   <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      rider_lean <= '0;
      a2d_val    <= '0;
      tx_data    <= '0;
    end else begin
      state    <= state_nxt;
      step_idx <= idx_nxt;
      cnt      <= cnt_nxt;
      done     <= done_nxt;
      if (state == S_APPLY && !abort) begin
        rider_lean <= cur.lean;
        a2d_val    <= cur.a2d;
        tx_data    <= cur.cmd;
      end
    end
  end

  assign trmt = (state == S_SEND) && !abort;

  assign busy = (state == S_APPLY) || (state == S_SEND) ||
                (state == S_WAIT_TX) || (state == S_DELAY);

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer: directed step programs, expected
// output events queued by the stimulus and matched by a negedge monitor.
module tb_stim_sequencer;
  import stim_pkg::*;

  localparam int K_OUT  = 0;
  localparam int K_TX   = 1;
  localparam int K_DONE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic        wr_cmd_vld;
  logic [7:0]  wr_cmd;
  logic [15:0] wr_lean;
  logic [47:0] wr_a2d;
  logic [23:0] wr_dly;
  logic        wr_last;
  logic        start;
  logic        abort;
  logic        loop_en;
  logic        tx_done;
  logic        trmt;
  logic [7:0]  tx_data;
  logic [15:0] rider_lean;
  logic [47:0] a2d_val;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;

  typedef struct {
    int          kind;
    int          rel;
    logic [63:0] data;
  } ev_t;

  ev_t         q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  bit          mon_on = 0;
  logic [63:0] prev = '0;

  stim_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_cmd_vld (wr_cmd_vld),
    .wr_cmd     (wr_cmd),
    .wr_lean    (wr_lean),
    .wr_a2d     (wr_a2d),
    .wr_dly     (wr_dly),
    .wr_last    (wr_last),
    .start      (start),
    .abort      (abort),
    .loop_en    (loop_en),
    .tx_done    (tx_done),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .rider_lean (rider_lean),
    .a2d_val    (a2d_val),
    .busy       (busy),
    .done       (done),
    .step_idx   (step_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int rel, input logic [63:0] data);
    ev_t e;
    e.kind = kind;
    e.rel  = rel;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [63:0] data,
                         input string nm);
    ev_t e;
    int  rel;
    rel = cyc - t0;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected at rel %0d got %h required none",
               nm, rel, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.rel != rel || e.data !== data) begin
        errors++;
        $display("FAIL %s got kind %0d rel %0d data %h required kind %0d rel %0d data %h",
                 nm, kind, rel, data, e.kind, e.rel, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] now;
    now = {rider_lean, a2d_val};
    if (mon_on && !rst) begin
      if (now !== prev) pop_cmp(K_OUT, now, "out");
      if (trmt) pop_cmp(K_TX, {56'h0, tx_data}, "tx");
      if (done) pop_cmp(K_DONE, 64'h0, "done");
    end
    prev = now;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int r);
    int n;
    n = 0;
    while (cyc < t0 + r && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wr(input int a, input logic cv, input logic [7:0] c,
                    input logic [15:0] l, input logic [47:0] av,
                    input logic [23:0] d, input logic lst);
    wr_en      = 1'b1;
    wr_addr    = 4'(a);
    wr_cmd_vld = cv;
    wr_cmd     = c;
    wr_lean    = l;
    wr_a2d     = av;
    wr_dly     = d;
    wr_last    = lst;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go();
    t0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_trmt"}, 64'(trmt), 64'h0);
    chk({nm, "_txd"}, 64'(tx_data), 64'h0);
    chk({nm, "_out"}, {rider_lean, a2d_val}, 64'h0);
    chk({nm, "_busy"}, 64'(busy), 64'h0);
    chk({nm, "_done"}, 64'(done), 64'h0);
    chk({nm, "_idx"}, 64'(step_idx), 64'h0);
    chk({nm, "_state"}, 64'(dut.state), 64'(S_IDLE));
  endtask

  logic [47:0] a_go;
  logic [47:0] a_ab;

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_cmd_vld = 0; wr_cmd = 0; wr_lean = 0;
    wr_a2d = 0; wr_dly = 0; wr_last = 0;
    start = 0; abort = 0; loop_en = 0; tx_done = 0;
    tick();
    tick();
    chk_zero("rst0");
    rst = 1'b0;
    tick();
    mon_on = 1;

    // single go step with command and tx handshake
    a_go = {12'hFFF, 12'h800, 12'h400, 12'h400};
    wr(0, 1'b1, CMD_GO, 16'h0000, a_go, 24'd10, 1'b1);
    tick();
    push(K_OUT, 2, {16'h0000, a_go});
    push(K_TX, 2, 64'h67);
    push(K_DONE, 31, 64'h0);
    go();
    wait_rel(20);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_rel(34);
    chk("q_go", 64'(q.size()), 64'h0);

    // three timed steps, no commands
    wr(0, 1'b0, 8'h00, 16'h0FFF, 48'h111222333444, 24'd5, 1'b0);
    wr(1, 1'b0, 8'h00, 16'h0000, 48'h555666777888, 24'd5, 1'b0);
    wr(2, 1'b0, 8'h00, 16'hF001, 48'h999AAABBBCCC, 24'd5, 1'b1);
    push(K_OUT, 2, {16'h0FFF, 48'h111222333444});
    push(K_OUT, 8, {16'h0000, 48'h555666777888});
    push(K_OUT, 14, {16'hF001, 48'h999AAABBBCCC});
    push(K_DONE, 19, 64'h0);
    go();
    wait_rel(2);
    chk("idx_s0", 64'(step_idx), 64'd0);
    wait_rel(8);
    chk("idx_s1", 64'(step_idx), 64'd1);
    wait_rel(14);
    chk("idx_s2", 64'(step_idx), 64'd2);
    wait_rel(22);
    chk("q_three", 64'(q.size()), 64'h0);

    // looping over two steps, then release loop_en
    wr(0, 1'b0, 8'h00, 16'h0100, 48'h1, 24'd3, 1'b0);
    wr(1, 1'b0, 8'h00, 16'h0200, 48'h2, 24'd3, 1'b1);
    loop_en = 1'b1;
    push(K_OUT, 2, {16'h0100, 48'h1});
    push(K_OUT, 6, {16'h0200, 48'h2});
    push(K_OUT, 10, {16'h0100, 48'h1});
    push(K_OUT, 14, {16'h0200, 48'h2});
    push(K_DONE, 17, 64'h0);
    go();
    wait_rel(10);
    chk("idx_wrap", 64'(step_idx), 64'd0);
    wait_rel(12);
    loop_en = 1'b0;
    wait_rel(20);
    chk("q_loop", 64'(q.size()), 64'h0);

    // abort in WAIT_TX, replay, then start+abort together
    a_ab = 48'hABC_DEF_123_456;
    wr(0, 1'b1, CMD_STOP, 16'h1234, a_ab, 24'd2, 1'b1);
    push(K_OUT, 2, {16'h1234, a_ab});
    push(K_TX, 2, 64'h73);
    go();
    wait_rel(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_state", 64'(dut.state), 64'(S_IDLE));
    chk("ab_busy", 64'(busy), 64'h0);
    chk("ab_trmt", 64'(trmt), 64'h0);
    chk("ab_hold", {rider_lean, a2d_val}, {16'h1234, a_ab});
    wait_rel(8);
    push(K_TX, 2, 64'h73);
    push(K_DONE, 6, 64'h0);
    go();
    wait_rel(3);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_rel(9);
    chk("q_abort", 64'(q.size()), 64'h0);
    t0 = cyc;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy1", 64'(busy), 64'h0);
    tick();
    chk("sa_busy2", 64'(busy), 64'h0);
    chk("sa_state", 64'(dut.state), 64'(S_IDLE));

    // full table, zero delays, write attempt while busy
    for (int i = 0; i < 16; i++)
      wr(i, 1'b0, 8'h00, 16'(i + 1), 48'(i * 3 + 7), 24'd0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++)
        push(K_OUT, i + 2, {16'(i + 1), 48'(i * 3 + 7)});
      push(K_DONE, 17, 64'h0);
      go();
      if (r == 0) begin
        wait_rel(5);
        wr(3, 1'b1, 8'hEE, 16'hDEAD, 48'hBEEF, 24'd9, 1'b1);
      end
      wait_rel(16);
      chk("idx_last", 64'(step_idx), 64'd15);
      wait_rel(20);
      chk("q_full", 64'(q.size()), 64'h0);
    end

    // reset asserted in the middle of a long delay
    wr(0, 1'b0, 8'h00, 16'h5555, 48'h0A0B0C0D0E0F, 24'd50, 1'b1);
    push(K_OUT, 2, {16'h5555, 48'h0A0B0C0D0E0F});
    go();
    wait_rel(10);
    chk("q_pre_rst", 64'(q.size()), 64'h0);
    chk("busy_pre_rst", 64'(busy), 64'h1);
    mon_on = 0;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
